// File: rtl/serial_config_loader_if.sv
// Serial configuration loader bus: serial in/out, frame enable and the committed word.
interface serial_config_loader_if #(
   parameter int unsigned WIDTH = 8
);
   logic             SDI;
   logic             SEN;
   logic             SDO;
   logic [WIDTH-1:0] DOUT;
   logic             VALID;
   logic             ERR;

   // Driver side: supplies the serial stream and observes the loader.
   modport master (
      output SDI,
      output SEN,
      input  SDO,
      input  DOUT,
      input  VALID,
      input  ERR
   );

   // Loader side.
   modport slave (
      input  SDI,
      input  SEN,
      output SDO,
      output DOUT,
      output VALID,
      output ERR
   );
endinterface

// File: rtl/serial_config_loader.sv
// Serial-in/parallel-out configuration loader. Shifts a word in MSB-first while SEN is
// high and commits it to DOUT only if the frame held exactly WIDTH bits; otherwise ERR
// pulses and DOUT keeps its old value. SDO is the shadow MSB for daisy-chaining.
module serial_config_loader #(
   parameter int unsigned           WIDTH       = 8,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input logic                      CLK,
   input logic                      RESET,
   serial_config_loader_if.slave    bus
);

   localparam int unsigned CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   // State register; reset aborts any frame in flight without a commit or error.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= StIdle;
         shadow_q <= '0;
         count_q  <= '0;
         dout_q   <= RESET_VALUE;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   // Next-state: shift while SEN is high, judge the frame length on the first SEN-low edge.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      count_d  = count_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.SEN) begin
               shadow_d = {shadow_q[WIDTH-2:0], bus.SDI};
               count_d  = CW'(1);
               state_d  = StShift;
            end else begin
               state_d  = StIdle;
            end
         end
         StShift: begin
            if (bus.SEN) begin
               // Overrun bits keep shifting so the shadow holds the last WIDTH bits.
               shadow_d = {shadow_q[WIDTH-2:0], bus.SDI};
               count_d  = (count_q == CNT_MAX) ? CNT_MAX : count_q + CW'(1);
            end else begin
               if (count_q == CNT_FULL) begin
                  dout_d  = shadow_q;
                  valid_d = 1'b1;
               end else begin
                  err_d   = 1'b1;
               end
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.SDO   = shadow_q[WIDTH-1];
   assign bus.DOUT  = dout_q;
   assign bus.VALID = valid_q;
   assign bus.ERR   = err_q;

endmodule

// File: tb/tb_serial_config_loader.sv
// Bench for serial_config_loader: directed frames, expected commits/rejects queued per
// loader and checked by monitors whenever a loader pulses VALID or ERR.
module tb_serial_config_loader;

   typedef struct packed {
      logic       is_err;
      logic [7:0] dout;
   } exp_t;

   logic clk;
   logic rst_up;
   logic rst_dn;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t up_q[$];
   exp_t dn_q[$];

   serial_config_loader_if #(.WIDTH(8)) up_if ();
   serial_config_loader_if #(.WIDTH(8)) dn_if ();

   // Downstream loader is chained off the upstream serial output and shares its enable.
   assign dn_if.SDI = up_if.SDO;
   assign dn_if.SEN = up_if.SEN;

   serial_config_loader #(
      .WIDTH       (8),
      .RESET_VALUE (8'h3C)
   ) u_up (
      .CLK   (clk),
      .RESET (rst_up),
      .bus   (up_if)
   );

   serial_config_loader #(
      .WIDTH       (8),
      .RESET_VALUE (8'h3C)
   ) u_dn (
      .CLK   (clk),
      .RESET (rst_dn),
      .bus   (dn_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the last bit was sampled.
   task automatic shift_bits(input logic [15:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         up_if.SEN = 1'b1;
         up_if.SDI = data[n-1-i];
         @(posedge clk);
         #1;
      end
   endtask

   // Drops SEN; returns just after the edge that judges the frame.
   task automatic end_frame();
      up_if.SEN = 1'b0;
      up_if.SDI = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [15:0] data, input int n);
      shift_bits(data, n);
      end_frame();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Upstream monitor.
   always @(negedge clk) begin
      exp_t e;
      if (rst_up && (up_if.VALID || up_if.ERR)) begin
         check("up_valid_err_exclusive", 32'(up_if.VALID & up_if.ERR), 32'h0);
         n_tests++;
         if (up_q.size() == 0) begin
            n_fail++;
            $display("FAIL up_unexpected_pulse: got valid=%0b err=%0b, expected no pulse",
                     up_if.VALID, up_if.ERR);
         end else begin
            n_tests--;
            e = up_q.pop_front();
            check("up_pulse_kind_err", 32'(up_if.ERR), 32'(e.is_err));
            check("up_dout_at_pulse", 32'(up_if.DOUT), 32'(e.dout));
         end
      end
   end

   // Downstream monitor.
   always @(negedge clk) begin
      exp_t e;
      if (rst_dn && (dn_if.VALID || dn_if.ERR)) begin
         check("dn_valid_err_exclusive", 32'(dn_if.VALID & dn_if.ERR), 32'h0);
         n_tests++;
         if (dn_q.size() == 0) begin
            n_fail++;
            $display("FAIL dn_unexpected_pulse: got valid=%0b err=%0b, expected no pulse",
                     dn_if.VALID, dn_if.ERR);
         end else begin
            n_tests--;
            e = dn_q.pop_front();
            check("dn_pulse_kind_err", 32'(dn_if.ERR), 32'(e.is_err));
            check("dn_dout_at_pulse", 32'(dn_if.DOUT), 32'(e.dout));
         end
      end
   end

   initial begin
      up_if.SDI = 1'b0;
      up_if.SEN = 1'b0;
      rst_up    = 1'b0;
      rst_dn    = 1'b0;

      // Reset and quiet period.
      repeat (3) @(posedge clk);
      #1;
      check("reset_dout", 32'(up_if.DOUT), 32'h3C);
      check("reset_valid", 32'(up_if.VALID), 32'h0);
      check("reset_err", 32'(up_if.ERR), 32'h0);
      check("reset_sdo", 32'(up_if.SDO), 32'h0);
      rst_up = 1'b1;
      idle(20);
      check("idle_dout", 32'(up_if.DOUT), 32'h3C);
      check("idle_sdo", 32'(up_if.SDO), 32'h0);

      // Exact-length frame commits.
      up_q.push_back('{is_err: 1'b0, dout: 8'hA5});
      send_frame(16'h00A5, 8);
      check("a5_dout", 32'(up_if.DOUT), 32'hA5);
      check("a5_valid", 32'(up_if.VALID), 32'h1);
      check("a5_err", 32'(up_if.ERR), 32'h0);
      idle(3);

      // Short and overrun frames are rejected.
      up_q.push_back('{is_err: 1'b1, dout: 8'hA5});
      send_frame(16'h0016, 5);
      check("short_err", 32'(up_if.ERR), 32'h1);
      check("short_valid", 32'(up_if.VALID), 32'h0);
      idle(3);
      up_q.push_back('{is_err: 1'b1, dout: 8'hA5});
      send_frame(16'h02AB, 10);
      check("overrun_err", 32'(up_if.ERR), 32'h1);
      idle(3);
      check("overrun_dout_held", 32'(up_if.DOUT), 32'hA5);

      // Reset in the middle of a frame.
      shift_bits(16'h000D, 4);
      #2;
      rst_up    = 1'b0;
      up_if.SEN = 1'b0;
      #1;
      check("midreset_dout", 32'(up_if.DOUT), 32'h3C);
      check("midreset_valid", 32'(up_if.VALID), 32'h0);
      check("midreset_err", 32'(up_if.ERR), 32'h0);
      #1;
      rst_up = 1'b1;
      @(posedge clk);
      #1;
      up_q.push_back('{is_err: 1'b0, dout: 8'h0F});
      send_frame(16'h000F, 8);
      check("post_reset_0f", 32'(up_if.DOUT), 32'h0F);
      idle(3);

      // Back-to-back frames with the minimum one-cycle gap.
      up_q.push_back('{is_err: 1'b0, dout: 8'h81});
      up_q.push_back('{is_err: 1'b0, dout: 8'h7E});
      send_frame(16'h0081, 8);
      check("b2b_first_dout", 32'(up_if.DOUT), 32'h81);
      send_frame(16'h007E, 8);
      check("b2b_second_dout", 32'(up_if.DOUT), 32'h7E);
      check("b2b_second_valid", 32'(up_if.VALID), 32'h1);
      idle(3);

      // Daisy chain: both loaders fresh out of reset.
      rst_up = 1'b0;
      rst_dn = 1'b0;
      #2;
      rst_up = 1'b1;
      rst_dn = 1'b1;
      @(posedge clk);
      #1;
      // 16 bits overrun both; upstream keeps 8'hEF, downstream receives 8'hBE.
      up_q.push_back('{is_err: 1'b1, dout: 8'h3C});
      dn_q.push_back('{is_err: 1'b1, dout: 8'h3C});
      send_frame(16'hBEEF, 16);
      // Downstream shifts in the upstream's previous shadow contents each frame.
      up_q.push_back('{is_err: 1'b0, dout: 8'hEF});
      dn_q.push_back('{is_err: 1'b0, dout: 8'hEF});
      send_frame(16'h00EF, 8);
      up_q.push_back('{is_err: 1'b0, dout: 8'hBE});
      dn_q.push_back('{is_err: 1'b0, dout: 8'hEF});
      send_frame(16'h00BE, 8);
      idle(3);
      check("chain_up_dout", 32'(up_if.DOUT), 32'hBE);
      check("chain_dn_dout", 32'(dn_if.DOUT), 32'hEF);

      check("up_pending_expectations", 32'(up_q.size()), 32'h0);
      check("dn_pending_expectations", 32'(dn_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
